mcu_dbg_probe: RTL and testbench
================================

MCU_DBG_PROBE -- requirements
Module: mcu_dbg_probe

Interface
REQ-001 Parameter NGRP, default 4: number of probe groups; SHALL be 2..16.
REQ-002 Parameter W, default 32: width of each probe group and of test_out.
REQ-003 Parameter DEPTH, default 8: capture buffer depth; SHALL be a power of 2, 2..64.
REQ-004 Parameter SELW, default 2: test_sel width; SHALL be at least ceil(log2(NGRP)).
REQ-005 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 test_sel  in  SELW  selects the probe group.
REQ-008 probe_in  in  NGRP*W  flat probe bus; group g occupies bits [g*W+W-1 : g*W].
REQ-009 trig_mask  in  W  trigger compare mask; 1 = bit compared.
REQ-010 trig_val  in  W  trigger compare value.
REQ-011 arm  in  1  single-cycle pulse that clears the buffer and arms the trigger.
REQ-012 rd_req  in  1  single-cycle pulse requesting one captured sample.
REQ-013 test_out  out  W  registered live view of the selected group.
REQ-014 trig_hit  out  1  one-cycle pulse when the trigger fires.
REQ-015 cap_state  out  2  state code: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 rd_valid  out  1  qualifies rd_data for exactly one cycle.
REQ-017 rd_data  out  W  captured sample being read out.
REQ-018 cap_cnt  out  log2(DEPTH)+1  number of unread samples in the buffer.

Function
REQ-019 test_out SHALL equal probe_in group test_sel, one cycle after test_sel and probe_in are sampled.
REQ-020 test_sel >= NGRP SHALL give test_out = 0.
REQ-021 The trigger match SHALL be ((test_out XOR trig_val) AND trig_mask) == 0, evaluated on the registered test_out.
REQ-022 trig_mask = 0 SHALL match on the first ARMED cycle.
REQ-023 IDLE: arm SHALL go to ARMED; all other inputs except test_sel are ignored.
REQ-024 ARMED, match true:
  - go to CAPTURE next cycle;
  - write the current test_out as sample 0;
  - pulse trig_hit for that one cycle.
REQ-025 CAPTURE SHALL write test_out every cycle until DEPTH samples are stored, then go to DONE with cap_cnt = DEPTH.
REQ-026 Samples SHALL be stored in arrival order; the buffer SHALL never hold more than DEPTH samples; the write pointer SHALL wrap modulo DEPTH.
REQ-027 Changing test_sel during CAPTURE SHALL NOT restart capture; samples follow the new group with test_out's one-cycle latency.
REQ-028 DONE with rd_req and cap_cnt > 0:
  - next cycle rd_valid = 1 and rd_data = oldest unread sample;
  - cap_cnt decrements by 1;
  - the read pointer advances, wrapping modulo DEPTH.
REQ-029 rd_req with cap_cnt = 0 or in states other than DONE SHALL be ignored: rd_valid stays 0, nothing changes.
REQ-030 Back-to-back rd_req pulses SHALL each return one sample on consecutive cycles.
REQ-031 DONE with cap_cnt = 0 SHALL remain in DONE until arm.
REQ-032 arm in any state SHALL, next cycle:
  - set cap_cnt = 0;
  - reset both buffer pointers;
  - enter ARMED, aborting any capture or readout.
REQ-033 arm and rd_req in the same cycle: arm wins and rd_valid stays 0.
REQ-034 rd_data SHALL hold its last value when rd_valid = 0.

Reset
REQ-035 While sys_rst = 1, on each rising edge of sys_clk:
  - test_out = 0, trig_hit = 0, rd_valid = 0, rd_data = 0, cap_cnt = 0;
  - cap_state = IDLE, pointers = 0.
REQ-036 Reset mid-capture or mid-readout SHALL discard all buffer content, with no partial readout afterwards.
REQ-037 Buffer memory contents need not be reset.

Verification (NGRP=4, W=32, DEPTH=8)
REQ-038 test_sel=2, group 2 = 32'hA5A5_0001 -> test_out = 32'hA5A5_0001 one cycle later; test_sel=3 with NGRP=3 build -> test_out = 0.
REQ-039 arm; trig_mask=32'hFFFF, trig_val=32'h0005; group 0 counts 0,1,2,... -> trig_hit when test_out=5, cap_state 1->2->3, cap_cnt=8; eight rd_req return 5..12, then cap_cnt=0.
REQ-040 In DONE with cap_cnt=0, rd_req -> rd_valid stays 0; in ARMED, rd_req -> ignored.
REQ-041 arm during CAPTURE after 3 samples -> cap_cnt=0, cap_state=1; the next trigger captures a fresh 8 samples.
REQ-042 sys_rst for one cycle in DONE with cap_cnt=4 -> all outputs 0, cap_state=0; rd_req afterwards -> no rd_valid.
REQ-043 arm and rd_req in the same cycle in DONE with cap_cnt=8 -> rd_valid=0, cap_cnt=0, cap_state=1.

Source files
------------

// File: rtl/mcu_dbg_probe.sv
// mcu_dbg_probe: live probe-group mux with a masked trigger and a DEPTH-deep capture buffer.
module mcu_dbg_probe #(
    parameter int NGRP  = 4,
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int SELW  = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [SELW-1:0]          test_sel,
    input  logic [NGRP*W-1:0]        probe_in,
    input  logic [W-1:0]             trig_mask,
    input  logic [W-1:0]             trig_val,
    input  logic                     arm,
    input  logic                     rd_req,
    output logic [W-1:0]             test_out,
    output logic                     trig_hit,
    output logic [1:0]               cap_state,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   cap_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t        r_state;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [W-1:0]  w_sel;
    logic          w_match, w_wr, w_rd;
    // out-of-range selects fall through to zero
    always_comb begin
        w_sel = '0;
        for (int g = 0; g < NGRP; g++)
            if (test_sel == SELW'(g)) w_sel = probe_in[g*W +: W];
    end
    assign w_match   = ((test_out ^ trig_val) & trig_mask) == '0;
    assign w_wr      = !arm && (r_state == CAPTURE || (r_state == ARMED && w_match));
    assign w_rd      = !arm && r_state == DONE && rd_req && cap_cnt != '0;
    assign cap_state = r_state;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            test_out <= '0;
            trig_hit <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            cap_cnt  <= '0;
            r_state  <= IDLE;
            r_wp     <= '0;
            r_rp     <= '0;
        end else begin
            test_out <= w_sel;
            trig_hit <= !arm && r_state == ARMED && w_match;
            rd_valid <= w_rd;
            if (w_rd) begin
                rd_data <= r_mem[r_rp];
                r_rp    <= r_rp + 1'b1;
            end
            if (arm) begin
                r_state <= ARMED;
                cap_cnt <= '0;
                r_wp    <= '0;
                r_rp    <= '0;
            end else if (w_wr) begin
                r_wp    <= r_wp + 1'b1;
                cap_cnt <= cap_cnt + 1'b1;
                r_state <= (cap_cnt == (AW+1)'(DEPTH-1)) ? DONE : CAPTURE;
            end else if (w_rd) begin
                cap_cnt <= cap_cnt - 1'b1;
            end
        end
    end
    always_ff @(posedge sys_clk)
        if (w_wr) r_mem[r_wp] <= test_out;
endmodule

// File: tb/tb_mcu_dbg_probe.sv
// tb_mcu_dbg_probe: directed stimulus with a readout scoreboard for mcu_dbg_probe.
module tb_mcu_dbg_probe;
    logic         clk = 1'b0, rst = 1'b1;
    logic [1:0]   sel = '0, sel_b = '0;
    logic [127:0] probe = '0;
    logic [95:0]  probe_b = {3{32'hFFFF_FFFF}};
    logic [31:0]  mask = '0, val = '0;
    logic         arm = 1'b0, rd_req = 1'b0, cnt_en = 1'b0;
    logic [31:0]  test_out, rd_data, test_out_b, rd_data_b;
    logic         trig_hit, rd_valid, trig_hit_b, rd_valid_b;
    logic [1:0]   cap_state, cap_state_b;
    logic [3:0]   cap_cnt, cap_cnt_b;
    int           checks = 0, errors = 0;
    logic [31:0]  sb [$];

    always #5 clk = ~clk;

    mcu_dbg_probe #(.NGRP(4), .W(32), .DEPTH(8), .SELW(2)) dut (
        .sys_clk(clk), .sys_rst(rst), .test_sel(sel), .probe_in(probe),
        .trig_mask(mask), .trig_val(val), .arm(arm), .rd_req(rd_req),
        .test_out(test_out), .trig_hit(trig_hit), .cap_state(cap_state),
        .rd_valid(rd_valid), .rd_data(rd_data), .cap_cnt(cap_cnt));

    mcu_dbg_probe #(.NGRP(3), .W(32), .DEPTH(8), .SELW(2)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .test_sel(sel_b), .probe_in(probe_b),
        .trig_mask(32'h0), .trig_val(32'h0), .arm(1'b0), .rd_req(1'b0),
        .test_out(test_out_b), .trig_hit(trig_hit_b), .cap_state(cap_state_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .cap_cnt(cap_cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every rd_valid must match the oldest expected sample
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) chk("unexpected_rd_valid", rd_data, 32'hDEAD_BEEF ^ rd_data);
            else chk("rd_data", rd_data, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_en) probe[31:0] = probe[31:0] + 1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_trig();
        for (int n = 0; n < 40 && !trig_hit; n++) tick();
        chk("trig_hit", {31'b0, trig_hit}, 32'd1);
        chk("state_capture", {30'b0, cap_state}, 32'd2);
    endtask

    task automatic wait_done();
        tick();
        chk("trig_hit_one_cycle", {31'b0, trig_hit}, 32'd0);
        for (int n = 0; n < 40 && cap_state != 2'd3; n++) tick();
        chk("state_done", {30'b0, cap_state}, 32'd3);
        chk("cnt_full", {28'b0, cap_cnt}, 32'd8);
    endtask

    task automatic read_n(input int n, input logic [31:0] first);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            sb.push_back(first + 32'(i));
            tick();
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic capture_from_zero();
        sel = 2'd0;
        mask = 32'hFFFF;
        val = 32'h5;
        probe[31:0] = '0;
        cnt_en = 1'b1;
        pulse_arm();
        wait_trig();
        wait_done();
        cnt_en = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_test_out", test_out, 32'h0);
        chk("rst_state", {30'b0, cap_state}, 32'd0);
        chk("rst_cnt", {28'b0, cap_cnt}, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_trig_hit", {31'b0, trig_hit}, 32'd0);
        rst = 1'b0;
        sel = 2'd2;
        probe[95:64] = 32'hA5A5_0001;
        sel_b = 2'd3;
        tick();
        chk("mux_grp2", test_out, 32'hA5A5_0001);
        chk("mux_oob_ngrp3", test_out_b, 32'h0);
        sel_b = 2'd1;
        tick();
        chk("mux_ngrp3_grp1", test_out_b, 32'hFFFF_FFFF);
        chk("idle_state", {30'b0, cap_state}, 32'd0);
        // first capture, with an ignored read while armed
        sel = 2'd0;
        mask = 32'hFFFF;
        val = 32'h5;
        probe[31:0] = '0;
        cnt_en = 1'b1;
        pulse_arm();
        chk("armed_state", {30'b0, cap_state}, 32'd1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("armed_rd_ignored", {31'b0, rd_valid}, 32'd0);
        chk("armed_still", {30'b0, cap_state}, 32'd1);
        wait_trig();
        wait_done();
        cnt_en = 1'b0;
        read_n(8, 32'd5);
        chk("cnt_empty", {28'b0, cap_cnt}, 32'd0);
        chk("rd_data_hold", rd_data, 32'd12);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("empty_rd_ignored", {31'b0, rd_valid}, 32'd0);
        chk("empty_stays_done", {30'b0, cap_state}, 32'd3);
        // abort mid-capture, then recapture
        probe[31:0] = '0;
        cnt_en = 1'b1;
        pulse_arm();
        wait_trig();
        tick();
        tick();
        chk("cnt_three", {28'b0, cap_cnt}, 32'd3);
        pulse_arm();
        probe[31:0] = '0;
        chk("abort_cnt", {28'b0, cap_cnt}, 32'd0);
        chk("abort_state", {30'b0, cap_state}, 32'd1);
        wait_trig();
        wait_done();
        cnt_en = 1'b0;
        read_n(8, 32'd5);
        chk("recap_empty", {28'b0, cap_cnt}, 32'd0);
        // reset in DONE with four unread samples
        capture_from_zero();
        read_n(4, 32'd5);
        chk("cnt_four", {28'b0, cap_cnt}, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_state", {30'b0, cap_state}, 32'd0);
        chk("rst2_cnt", {28'b0, cap_cnt}, 32'd0);
        chk("rst2_test_out", test_out, 32'h0);
        chk("rst2_rd_data", rd_data, 32'h0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("rst2_rd_ignored", {31'b0, rd_valid}, 32'd0);
        // zero mask fires on the first armed cycle; then arm beats rd_req
        mask = '0;
        pulse_arm();
        tick();
        chk("mask0_hit", {31'b0, trig_hit}, 32'd1);
        chk("mask0_state", {30'b0, cap_state}, 32'd2);
        for (int n = 0; n < 40 && cap_state != 2'd3; n++) tick();
        chk("mask0_full", {28'b0, cap_cnt}, 32'd8);
        arm = 1'b1;
        rd_req = 1'b1;
        tick();
        arm = 1'b0;
        rd_req = 1'b0;
        chk("arm_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("arm_rd_cnt", {28'b0, cap_cnt}, 32'd0);
        chk("arm_rd_state", {30'b0, cap_state}, 32'd1);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
